// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue controller: a local copy of the ariane_pkg
// fu_data_t / fu_op subset used here, plus the writeback FIFO entry.
package alu_issue_pkg;

  localparam int TRANS_ID_W    = 3;
  localparam int WB_DEPTH_DFLT = 4;
  localparam int WB_PTR_W      = $clog2(WB_DEPTH_DFLT);

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    ANDL = 4'd2,
    ORL  = 4'd3,
    XORL = 4'd4,
    EQ   = 4'd5,
    NE   = 4'd6,
    LTS  = 4'd7
  } fu_op;

  typedef struct packed {
    fu_op                  operator;
    logic [63:0]           operand_a;
    logic [63:0]           operand_b;
    logic [63:0]           imm;
    logic [TRANS_ID_W-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [TRANS_ID_W-1:0] trans_id;
    logic [63:0]           result;
    logic                  branch_res;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// Writeback FIFO holding ALU results until the commit side takes them.
// Flush empties it at the next edge and overrides any push or pop.
module alu_wb_fifo
  import alu_issue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = wb_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  ENTRY_T                     data_i,
  output ENTRY_T                     data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  ENTRY_T             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W-1:0]   r_wrPtr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rdPtr];

  assign w_push = push_i & ~full_o & ~flush_i;
  assign w_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr] <= data_i;
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full_o));
      assert (!(pop_i && empty_o));
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage S1 feeding the combinational ALU, with results collected into a writeback FIFO.
// Optional perf counters are enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WB_DEPTH      = WB_DEPTH_DFLT,
  parameter int TRANS_ID_BITS = TRANS_ID_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  fu_data_t                      issue_data_i,
  output fu_data_t                      alu_data_o,
  input  logic [63:0]                   alu_result_i,
  input  logic                          alu_branch_res_i,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [TRANS_ID_BITS-1:0]      wb_trans_id_o,
  output logic [63:0]                   wb_result_o,
  output logic                          wb_branch_res_o,
  output logic [$clog2(WB_DEPTH+2)-1:0] in_flight_o
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]                   perf_ops_o,
  output logic [31:0]                   perf_stall_o
`endif
);

  localparam int CNT_W = $clog2(WB_DEPTH+1);
  localparam int IF_W  = $clog2(WB_DEPTH+2);

  logic             r_s1Valid;
  fu_data_t         r_s1Data;
  logic             w_fifoFull;
  logic             w_fifoEmpty;
  logic [CNT_W-1:0] w_fifoCount;
  logic             w_s1Adv;
  logic             w_accept;
  logic             w_pop;
  wb_entry_t        w_pushEntry;
  wb_entry_t        w_head;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign w_s1Adv       = r_s1Valid & ~w_fifoFull;
  assign issue_ready_o = ~r_s1Valid | w_s1Adv;
  assign w_accept      = issue_valid_i & issue_ready_o;
  assign w_pop         = ~w_fifoEmpty & wb_ready_i;

  always_comb begin
    w_pushEntry            = '0;
    w_pushEntry.trans_id   = r_s1Data.trans_id;
    w_pushEntry.result     = alu_result_i;
    w_pushEntry.branch_res = alu_branch_res_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
    end else if (flush_i) begin
      r_s1Valid <= 1'b0;
    end else if (w_accept) begin
      r_s1Valid <= 1'b1;
      r_s1Data  <= issue_data_i;
    end else if (w_s1Adv) begin
      r_s1Valid <= 1'b0;
    end
  end

  alu_wb_fifo #(
    .DEPTH   (WB_DEPTH),
    .ENTRY_T (wb_entry_t)
  ) u_wbFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_s1Adv),
    .pop_i   (w_pop),
    .data_i  (w_pushEntry),
    .data_o  (w_head),
    .full_o  (w_fifoFull),
    .empty_o (w_fifoEmpty),
    .count_o (w_fifoCount)
  );

  assign alu_data_o      = r_s1Data;
  assign wb_valid_o      = ~w_fifoEmpty;
  assign wb_trans_id_o   = w_fifoEmpty ? '0 : TRANS_ID_BITS'(w_head.trans_id);
  assign wb_result_o     = w_fifoEmpty ? '0 : w_head.result;
  assign wb_branch_res_o = ~w_fifoEmpty & w_head.branch_res;
  assign in_flight_o     = IF_W'(w_fifoCount) + IF_W'(r_s1Valid);

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perfOps;
  logic [31:0] r_perfStall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perfOps   <= '0;
      r_perfStall <= '0;
    end else if (flush_i) begin
      r_perfOps   <= '0;
      r_perfStall <= '0;
    end else begin
      if (w_pop)                   r_perfOps   <= r_perfOps + 32'd1;
      if (r_s1Valid & w_fifoFull)  r_perfStall <= r_perfStall + 32'd1;
    end
  end

  assign perf_ops_o   = r_perfOps;
  assign perf_stall_o = r_perfStall;
`endif

  always @(posedge clk_i) begin
    if (!rst_i) assert (in_flight_o <= IF_W'(WB_DEPTH + 1));
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios followed by random traffic,
// all checked against an in-order queue model of accepted ops.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int WB_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  fu_data_t    issue_data_i;
  fu_data_t    alu_data_o;
  logic [63:0] alu_result_i;
  logic        alu_branch_res_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [2:0]  wb_trans_id_o;
  logic [63:0] wb_result_o;
  logic        wb_branch_res_o;
  logic [2:0]  in_flight_o;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops_o;
  logic [31:0] perf_stall_o;
`endif

  int total = 0;
  int bad = 0;
  int mInFlight = 0;
  int mOps = 0;
  int mStall = 0;
  int mAccepts = 0;
  wb_entry_t expQ[$];
  wb_entry_t aluOut;

  always #5 clk_i = ~clk_i;

  alu_issue_ctrl #(
    .WB_DEPTH      (WB_DEPTH),
    .TRANS_ID_BITS (3)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_data_i     (issue_data_i),
    .alu_data_o       (alu_data_o),
    .alu_result_i     (alu_result_i),
    .alu_branch_res_i (alu_branch_res_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_trans_id_o    (wb_trans_id_o),
    .wb_result_o      (wb_result_o),
    .wb_branch_res_o  (wb_branch_res_o),
    .in_flight_o      (in_flight_o)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_ops_o       (perf_ops_o),
    .perf_stall_o     (perf_stall_o)
`endif
  );

  // Behavioural single-cycle ALU: what a given op should produce.
  function automatic wb_entry_t refAlu(input fu_data_t d);
    wb_entry_t e;
    e = '0;
    e.trans_id = d.trans_id;
    case (d.operator)
      ADD:  e.result = d.operand_a + d.operand_b;
      SUB:  e.result = d.operand_a - d.operand_b;
      ANDL: e.result = d.operand_a & d.operand_b;
      ORL:  e.result = d.operand_a | d.operand_b;
      XORL: e.result = d.operand_a ^ d.operand_b;
      EQ:   e.branch_res = (d.operand_a == d.operand_b);
      NE:   e.branch_res = (d.operand_a != d.operand_b);
      LTS:  e.branch_res = ($signed(d.operand_a) < $signed(d.operand_b));
      default: e = '0;
    endcase
    return e;
  endfunction

  always_comb begin
    aluOut           = refAlu(alu_data_o);
    alu_result_i     = aluOut.result;
    alu_branch_res_i = aluOut.branch_res;
  end

  function automatic fu_data_t mkOp(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                                    input logic [2:0] id);
    fu_data_t d;
    d = '0;
    d.operator  = op;
    d.operand_a = a;
    d.operand_b = b;
    d.trans_id  = id;
    return d;
  endfunction

  function automatic fu_data_t randOp();
    logic [63:0] a;
    logic [63:0] b;
    a = {$urandom, $urandom};
    b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
    return mkOp(fu_op'(4'($urandom_range(0, 7))), a, b, 3'($urandom_range(0, 7)));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    expQ.delete();
    mInFlight = 0;
    mOps = 0;
    mStall = 0;
  endtask

  // One clock: inputs are already driven; judge handshakes, update model, advance one edge.
  task automatic applyStimulus();
    logic acc;
    logic pp;
    wb_entry_t e;
    #1;
    acc = issue_valid_i & issue_ready_o;
    pp  = wb_valid_o & wb_ready_i;
    checkOutput("ready_vs_occupancy", 64'(issue_ready_o), 64'(mInFlight != WB_DEPTH + 1));
    if (!wb_valid_o) checkOutput("idle_wb_result", wb_result_o, 64'd0);
    if (flush_i) begin
      clearModel();
    end else begin
      if (mInFlight == WB_DEPTH + 1) mStall++;
      if (pp) begin
        if (expQ.size() == 0) begin
          checkOutput("pop_unexpected", 64'(pp), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_trans_id", 64'(wb_trans_id_o), 64'(e.trans_id));
          checkOutput("wb_result", wb_result_o, e.result);
          checkOutput("wb_branch_res", 64'(wb_branch_res_o), 64'(e.branch_res));
        end
        mInFlight--;
        mOps++;
      end
      if (acc) begin
        expQ.push_back(refAlu(issue_data_i));
        mInFlight++;
        mAccepts++;
      end
    end
    @(posedge clk_i);
    #1;
    checkOutput("in_flight", 64'(in_flight_o), 64'(mInFlight));
`ifdef ALU_ISSUE_PERF_EN
    checkOutput("perf_ops", 64'(perf_ops_o), 64'(mOps));
    checkOutput("perf_stall", 64'(perf_stall_o), 64'(mStall));
`endif
  endtask

  initial begin
    int base;
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    issue_data_i  = '0;
    wb_ready_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    // Reset state
    checkOutput("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    checkOutput("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    checkOutput("rst_in_flight", 64'(in_flight_o), 64'd0);
    checkOutput("rst_alu_data", 64'(|alu_data_o), 64'd0);
    checkOutput("rst_wb_trans_id", 64'(wb_trans_id_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Single ADD: result visible two edges after acceptance
    wb_ready_i    = 1'b1;
    issue_valid_i = 1'b1;
    issue_data_i  = mkOp(ADD, 64'd5, 64'd7, 3'd3);
    applyStimulus();
    issue_valid_i = 1'b0;
    checkOutput("lat_n1_wb_valid", 64'(wb_valid_o), 64'd0);
    applyStimulus();
    checkOutput("lat_n2_wb_valid", 64'(wb_valid_o), 64'd1);
    checkOutput("add_result", wb_result_o, 64'd12);
    checkOutput("add_trans_id", 64'(wb_trans_id_o), 64'd3);
    applyStimulus();

    // Branch compare EQ then NE on equal operands
    issue_valid_i = 1'b1;
    issue_data_i  = mkOp(EQ, 64'h10, 64'h10, 3'd1);
    applyStimulus();
    issue_data_i  = mkOp(NE, 64'h10, 64'h10, 3'd2);
    applyStimulus();
    issue_valid_i = 1'b0;
    checkOutput("eq_branch_res", 64'(wb_branch_res_o), 64'd1);
    applyStimulus();
    checkOutput("ne_branch_res", 64'(wb_branch_res_o), 64'd0);
    checkOutput("ne_trans_id", 64'(wb_trans_id_o), 64'd2);
    applyStimulus();

    // Backpressure: only WB_DEPTH+1 ops fit
    wb_ready_i    = 1'b0;
    issue_valid_i = 1'b1;
    base = mAccepts;
    for (int i = 0; i < 8; i++) begin
      issue_data_i = mkOp(ADD, 64'((mAccepts - base) * 10), 64'(mAccepts - base),
                          3'(mAccepts - base));
      applyStimulus();
    end
    checkOutput("bp_accepted", 64'(mAccepts - base), 64'd5);
    checkOutput("bp_issue_ready", 64'(issue_ready_o), 64'd0);
    checkOutput("bp_in_flight", 64'(in_flight_o), 64'd5);
    checkOutput("bp_s1_hold", 64'(alu_data_o.trans_id), 64'd4);
    issue_valid_i = 1'b0;
    wb_ready_i    = 1'b1;
    checkOutput("bp_head_id0", 64'(wb_trans_id_o), 64'd0);
    repeat (8) applyStimulus();
    checkOutput("bp_drained", 64'(wb_valid_o), 64'd0);

    // Streaming: 20 back-to-back SUBs, one result per cycle
    for (int i = 0; i < 22; i++) begin
      issue_valid_i = (i < 20);
      issue_data_i  = mkOp(SUB, 64'(1000 + i * 3), 64'(i), 3'(i));
      if (i >= 2) checkOutput("stream_no_bubble", 64'(wb_valid_o), 64'd1);
      applyStimulus();
    end
    issue_valid_i = 1'b0;
    applyStimulus();

    // Flush with 3 in flight and a concurrent issue
    wb_ready_i    = 1'b0;
    issue_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_data_i = mkOp(XORL, 64'(i + 1), 64'hff, 3'(i));
      applyStimulus();
    end
    checkOutput("pre_flush_in_flight", 64'(in_flight_o), 64'd3);
    flush_i      = 1'b1;
    issue_data_i = mkOp(ADD, 64'd1, 64'd1, 3'd7);
    applyStimulus();
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    checkOutput("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    checkOutput("flush_in_flight", 64'(in_flight_o), 64'd0);
    checkOutput("flush_issue_ready", 64'(issue_ready_o), 64'd1);
    wb_ready_i = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("flush_dropped", 64'(wb_valid_o), 64'd0);

    // Reset in the middle of traffic
    wb_ready_i    = 1'b0;
    issue_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_data_i = randOp();
      applyStimulus();
    end
    issue_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    clearModel();
    checkOutput("midrst_async_wb_valid", 64'(wb_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    checkOutput("midrst_wb_valid", 64'(wb_valid_o), 64'd0);
    checkOutput("midrst_issue_ready", 64'(issue_ready_o), 64'd1);
    checkOutput("midrst_in_flight", 64'(in_flight_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      issue_valid_i = ($urandom_range(0, 3) != 0);
      wb_ready_i    = ($urandom_range(0, 2) != 0);
      flush_i       = ($urandom_range(0, 49) == 0);
      issue_data_i  = randOp();
      applyStimulus();
    end
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    wb_ready_i    = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("final_in_flight", 64'(in_flight_o), 64'd0);
    checkOutput("final_model_empty", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
